// File: rtl/sdram_arb_pkg.sv
// Shared encodings for the SDRAM port arbiter: FSM states, operation codes and port ids.
package sdram_arb_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } arb_state_e;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } arb_op_e;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;
endpackage

// File: rtl/arb_rr2.sv
// Two-input picker: round-robin against the last served port, or fixed priority to port 0.
module arb_rr2
  import sdram_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_i,
  input  logic       rr_en_i,
  output logic [1:0] gnt_o,
  output logic       gnt_idx_o
);
  always_comb begin
    gnt_idx_o = PORT_CPU;
    if (req_i == 2'b11) begin
      gnt_idx_o = rr_en_i ? ~last_i : PORT_CPU;
    end else if (req_i[1]) begin
      gnt_idx_o = PORT_DMA;
    end
    gnt_o = {gnt_idx_o, ~gnt_idx_o} & {2{|req_i}};
  end
endmodule

// File: rtl/sdram_port_arbiter.sv
// Serialises CPU (port 0) and DMA (port 1) transactions onto one SDRAM controller, with
// per-port busy/ready handshakes, registered read data and a saturating stall watchdog.
module sdram_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int AW      = 24,
  parameter int DW      = 16,
  parameter int RW      = 32,
  parameter int RR      = 1,
  parameter int TIMEOUT = 1023
) (
  input  logic          clki,
  input  logic          rst_in,
  input  logic          p0_read,
  input  logic          p0_write,
  input  logic [AW-1:0] p0_addr,
  input  logic [DW-1:0] p0_wdata,
  output logic          p0_busy,
  output logic          p0_ready,
  output logic [RW-1:0] p0_rdata,
  output logic          p0_err,
  input  logic          p1_read,
  input  logic          p1_write,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_wdata,
  output logic          p1_busy,
  output logic          p1_ready,
  output logic [RW-1:0] p1_rdata,
  output logic          p1_err,
  output logic          sd_read,
  output logic          sd_write,
  output logic [AW-1:0] sd_addr,
  output logic [DW-1:0] sd_wdata,
  input  logic          sd_busy,
  input  logic          sd_ready,
  input  logic [RW-1:0] sd_rdata
);
  localparam int CW = $clog2(TIMEOUT + 1);

  arb_state_e    state_q, state_d;
  logic [1:0]    req, gnt;
  logic          gnt_idx;
  logic          latch, finish, abort, timeout;
  logic          sel_write;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic          gnt_q, last_q;
  arb_op_e       op_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [CW-1:0] cnt_q;
  logic [1:0]    busy_q, ready_q, err_q;
  logic [RW-1:0] rdata0_q, rdata1_q;

  assign req = {p1_read | p1_write, p0_read | p0_write};

  arb_rr2 u_pick (
    .req_i     (req),
    .last_i    (last_q),
    .rr_en_i   (RR != 0),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx)
  );

  // A simultaneous read+write on one port resolves to the write.
  assign sel_write = gnt[1] ? p1_write : p0_write;
  assign sel_addr  = gnt[1] ? p1_addr  : p0_addr;
  assign sel_wdata = gnt[1] ? p1_wdata : p0_wdata;
  assign timeout   = (cnt_q == CW'(TIMEOUT));

  always_ff @(posedge clki or negedge rst_in) begin
    if (!rst_in) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    latch   = 1'b0;
    finish  = 1'b0;
    abort   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          latch   = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE, ST_WAIT: begin
        if (sd_ready) begin
          finish  = 1'b1;
          state_d = ST_DONE;
        end else if (timeout) begin
          finish  = 1'b1;
          abort   = 1'b1;
          state_d = ST_DONE;
        end else if (state_q == ST_ISSUE && sd_busy) begin
          state_d = ST_WAIT;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clki or negedge rst_in) begin
    if (!rst_in) begin
      gnt_q    <= PORT_CPU;
      last_q   <= PORT_DMA;
      op_q     <= OP_RD;
      addr_q   <= '0;
      wdata_q  <= '0;
      cnt_q    <= '0;
      busy_q   <= '0;
      ready_q  <= '0;
      err_q    <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      ready_q <= '0;
      err_q   <= '0;
      if (latch) begin
        gnt_q   <= gnt_idx;
        op_q    <= sel_write ? OP_WR : OP_RD;
        addr_q  <= sel_addr;
        wdata_q <= sel_wdata;
        cnt_q   <= '0;
        busy_q  <= gnt;
      end else if ((state_q == ST_ISSUE || state_q == ST_WAIT) && !timeout) begin
        cnt_q <= cnt_q + CW'(1);
      end
      if (finish) begin
        busy_q         <= '0;
        ready_q[gnt_q] <= 1'b1;
        err_q[gnt_q]   <= abort;
      end
      // Read data is only refreshed by a genuine read completion, never by a write or an abort.
      if (finish && !abort && op_q == OP_RD) begin
        if (gnt_q == PORT_CPU) rdata0_q <= sd_rdata;
        else                   rdata1_q <= sd_rdata;
      end
      if (state_q == ST_DONE) last_q <= gnt_q;
    end
  end

  assign p0_busy  = busy_q[PORT_CPU];
  assign p1_busy  = busy_q[PORT_DMA];
  assign p0_ready = ready_q[PORT_CPU];
  assign p1_ready = ready_q[PORT_DMA];
  assign p0_err   = err_q[PORT_CPU];
  assign p1_err   = err_q[PORT_DMA];
  assign p0_rdata = rdata0_q;
  assign p1_rdata = rdata1_q;
  assign sd_read  = (state_q == ST_ISSUE) && (op_q == OP_RD);
  assign sd_write = (state_q == ST_ISSUE) && (op_q == OP_WR);
  assign sd_addr  = addr_q;
  assign sd_wdata = wdata_q;
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Scoreboard bench for sdram_port_arbiter: a round-robin instance with a scripted SDRAM model,
// plus a fixed-priority instance with an instant responder used for the starvation case.
module tb_sdram_port_arbiter;
  localparam int AW  = 24;
  localparam int DW  = 16;
  localparam int RW  = 32;
  localparam int TMO = 15;

  logic clki;
  logic rst_in;
  logic p0_read, p0_write, p1_read, p1_write;
  logic [AW-1:0] p0_addr, p1_addr;
  logic [DW-1:0] p0_wdata, p1_wdata;
  logic p0_busy, p0_ready, p0_err, p1_busy, p1_ready, p1_err;
  logic [RW-1:0] p0_rdata, p1_rdata;
  logic sd_read, sd_write, sd_busy, sd_ready;
  logic [AW-1:0] sd_addr;
  logic [DW-1:0] sd_wdata;
  logic [RW-1:0] sd_rdata;

  logic u2_p0_busy, u2_p0_ready, u2_p0_err, u2_p1_busy, u2_p1_ready, u2_p1_err;
  logic [RW-1:0] u2_p0_rdata, u2_p1_rdata;
  logic u2_sd_read, u2_sd_write, u2_sd_busy, u2_sd_ready;
  logic [AW-1:0] u2_sd_addr;
  logic [DW-1:0] u2_sd_wdata;
  logic [RW-1:0] u2_sd_rdata;

  initial clki = 1'b0;
  always #5 clki = ~clki;

  sdram_port_arbiter #(.AW(AW), .DW(DW), .RW(RW), .RR(1), .TIMEOUT(TMO)) dut (
    .clki(clki), .rst_in(rst_in),
    .p0_read(p0_read), .p0_write(p0_write), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_busy(p0_busy), .p0_ready(p0_ready), .p0_rdata(p0_rdata), .p0_err(p0_err),
    .p1_read(p1_read), .p1_write(p1_write), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_busy(p1_busy), .p1_ready(p1_ready), .p1_rdata(p1_rdata), .p1_err(p1_err),
    .sd_read(sd_read), .sd_write(sd_write), .sd_addr(sd_addr), .sd_wdata(sd_wdata),
    .sd_busy(sd_busy), .sd_ready(sd_ready), .sd_rdata(sd_rdata)
  );

  sdram_port_arbiter #(.AW(AW), .DW(DW), .RW(RW), .RR(0), .TIMEOUT(TMO)) dut_fixed (
    .clki(clki), .rst_in(rst_in),
    .p0_read(p0_read), .p0_write(p0_write), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_busy(u2_p0_busy), .p0_ready(u2_p0_ready), .p0_rdata(u2_p0_rdata), .p0_err(u2_p0_err),
    .p1_read(p1_read), .p1_write(p1_write), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_busy(u2_p1_busy), .p1_ready(u2_p1_ready), .p1_rdata(u2_p1_rdata), .p1_err(u2_p1_err),
    .sd_read(u2_sd_read), .sd_write(u2_sd_write), .sd_addr(u2_sd_addr), .sd_wdata(u2_sd_wdata),
    .sd_busy(u2_sd_busy), .sd_ready(u2_sd_ready), .sd_rdata(u2_sd_rdata)
  );

  typedef struct {
    logic          port;
    logic [RW-1:0] rdata;
    logic          err;
    int            busy;
  } rdy_t;

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } cmd_t;

  rdy_t rdy_q[$];
  cmd_t cmd_q[$];
  int   errors = 0;
  int   checks = 0;

  int            model_lat   = 3;
  bit            model_hang  = 1'b0;
  logic [RW-1:0] model_rdata = '0;
  logic [RW-1:0] exp_rd0 = '0;
  logic [RW-1:0] exp_rd1 = '0;
  bit            win = 1'b0;
  int            d2c0 = 0;
  int            d2c1 = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic on_ready(input logic port, input logic [RW-1:0] rd, input logic er, input int bc);
    rdy_t e;
    if (rdy_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_ready: port %0d pulsed ready, none expected", port);
      return;
    end
    e = rdy_q.pop_front();
    check("ready_port", 64'(port), 64'(e.port));
    check("rdata", 64'(rd), 64'(e.rdata));
    check("err", 64'(er), 64'(e.err));
    check("busy_len", 64'(bc), 64'(e.busy));
  endtask

  task automatic on_cmd();
    cmd_t e;
    if (cmd_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_cmd: addr %0h, none expected", sd_addr);
      return;
    end
    e = cmd_q.pop_front();
    check("cmd_rw", 64'({sd_write, sd_read}), 64'({e.wr, ~e.wr}));
    check("cmd_addr", 64'(sd_addr), 64'(e.addr));
    if (e.wr) check("cmd_wdata", 64'(sd_wdata), 64'(e.wdata));
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ctrl"}, 64'({p0_busy, p0_ready, p0_err, p1_busy, p1_ready, p1_err, sd_read, sd_write}), 64'd0);
    check({tag, "_rdata"}, {p0_rdata, p1_rdata}, 64'd0);
    check({tag, "_sd"}, 64'({sd_addr, sd_wdata}), 64'd0);
    check({tag, "_fixed_ctrl"}, 64'({u2_p0_busy, u2_p0_ready, u2_p0_err, u2_p1_busy, u2_p1_ready,
                                     u2_p1_err, u2_sd_read, u2_sd_write, u2_sd_addr, u2_sd_wdata}), 64'd0);
    check({tag, "_fixed_rdata"}, {u2_p0_rdata, u2_p1_rdata}, 64'd0);
  endtask

  // port 2 means either port
  task automatic wait_ready(input int port, input int limit);
    bit got = 1'b0;
    for (int n = 0; n < limit && !got; n++) begin
      @(negedge clki);
      got = (port == 0) ? p0_ready : (port == 1) ? p1_ready : (p0_ready | p1_ready);
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL wait_ready: no ready on port %0d within %0d cycles", port, limit);
    end
  endtask

  task automatic wait_in_wait(input string tag);
    bit got = 1'b0;
    for (int n = 0; n < 30 && !got; n++) begin
      @(negedge clki);
      got = sd_busy && !sd_read && !sd_write && (p0_busy | p1_busy);
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL %s: arbiter never reached the wait phase (got 0, need 1)", tag);
    end
  endtask

  // SDRAM model: busy from the cycle after the command, ready model_lat cycles after it.
  initial begin
    bit active = 1'b0;
    int k = 0;
    sd_busy = 1'b0;
    sd_ready = 1'b0;
    sd_rdata = '0;
    forever begin
      @(posedge clki);
      #1;
      sd_ready = 1'b0;
      sd_rdata = '0;
      if (!p0_busy && !p1_busy) begin
        active = 1'b0;
        sd_busy = 1'b0;
      end
      if (active) begin
        k++;
        if (!model_hang) begin
          if (k >= model_lat) begin
            sd_ready = 1'b1;
            sd_busy  = 1'b0;
            sd_rdata = model_rdata;
            active   = 1'b0;
          end else begin
            sd_busy = 1'b1;
          end
        end
      end else if (sd_read || sd_write) begin
        active = 1'b1;
        k = 0;
      end
    end
  end

  initial begin
    u2_sd_busy  = 1'b0;
    u2_sd_ready = 1'b0;
    u2_sd_rdata = '0;
    forever begin
      @(posedge clki);
      #1;
      u2_sd_ready = (u2_sd_read | u2_sd_write) && !u2_sd_ready;
    end
  end

  // Monitor: pops the scoreboard on every ready pulse and every new command.
  initial begin
    int   bcnt0 = 0;
    int   bcnt1 = 0;
    logic cmd_prev = 1'b0;
    forever begin
      @(negedge clki);
      if (!rst_in) begin
        bcnt0 = 0;
        bcnt1 = 0;
        cmd_prev = 1'b0;
      end else begin
        if (p0_busy) bcnt0++;
        if (p1_busy) bcnt1++;
        if (p0_ready) begin
          on_ready(1'b0, p0_rdata, p0_err, bcnt0);
          bcnt0 = 0;
        end
        if (p1_ready) begin
          on_ready(1'b1, p1_rdata, p1_err, bcnt1);
          bcnt1 = 0;
        end
        if ((sd_read | sd_write) && !cmd_prev) on_cmd();
        cmd_prev = sd_read | sd_write;
      end
      if (win) begin
        if (u2_p0_ready) d2c0++;
        if (u2_p1_ready) d2c1++;
      end
    end
  end

  initial begin
    int   n;
    bit   got;
    logic last_cmd;
    rst_in = 1'b0;
    p0_read = 1'b0; p0_write = 1'b0; p0_addr = '0; p0_wdata = '0;
    p1_read = 1'b0; p1_write = 1'b0; p1_addr = '0; p1_wdata = '0;
    repeat (3) @(negedge clki);
    check_zero("reset");
    rst_in = 1'b1;
    repeat (2) @(negedge clki);

    // Simultaneous writes right after reset: port 0 first, then port 1.
    model_lat = 3;
    p0_addr = 24'h000100; p0_wdata = 16'h1111;
    p1_addr = 24'h000200; p1_wdata = 16'h2222;
    cmd_q.push_back('{1'b1, 24'h000100, 16'h1111});
    cmd_q.push_back('{1'b1, 24'h000200, 16'h2222});
    rdy_q.push_back('{1'b0, exp_rd0, 1'b0, 4});
    rdy_q.push_back('{1'b1, exp_rd1, 1'b0, 4});
    p0_write = 1'b1; p1_write = 1'b1;
    @(negedge clki);
    check("tie_p0_busy", 64'(p0_busy), 64'd1);
    check("tie_p1_waits", 64'(p1_busy), 64'd0);
    wait_ready(0, 30);
    p0_write = 1'b0;
    wait_ready(1, 30);
    p1_write = 1'b0;
    repeat (5) @(negedge clki);

    // Continuous reads on both ports: round-robin alternates, fixed priority starves port 1.
    model_lat = 2; model_rdata = 32'h1234_5678;
    p0_addr = 24'h0A0A0A; p1_addr = 24'h0B0B0B;
    for (int i = 0; i < 4; i++) begin
      cmd_q.push_back('{1'b0, (i % 2 == 0) ? 24'h0A0A0A : 24'h0B0B0B, 16'h0000});
      rdy_q.push_back('{(i % 2 == 1), 32'h1234_5678, 1'b0, 3});
    end
    exp_rd0 = 32'h1234_5678; exp_rd1 = 32'h1234_5678;
    win = 1'b1;
    p0_read = 1'b1; p1_read = 1'b1;
    repeat (4) wait_ready(2, 30);
    p0_read = 1'b0; p1_read = 1'b0;
    win = 1'b0;
    check("fixed_p1_starved", 64'(d2c1), 64'd0);
    check("fixed_p0_served", 64'(d2c0 >= 4), 64'd1);
    repeat (5) @(negedge clki);

    // Single CPU read.
    model_lat = 5; model_rdata = 32'hDEAD_BEEF;
    p0_addr = 24'h000123;
    cmd_q.push_back('{1'b0, 24'h000123, 16'h0000});
    rdy_q.push_back('{1'b0, 32'hDEAD_BEEF, 1'b0, 6});
    exp_rd0 = 32'hDEAD_BEEF;
    p0_read = 1'b1;
    wait_ready(0, 30);
    p0_read = 1'b0;
    repeat (4) @(negedge clki);

    // Read+write together becomes a write; request withdrawn during the wait phase.
    model_lat = 6; model_rdata = 32'h5555_AAAA;
    p0_addr = 24'h000456; p0_wdata = 16'hBEEF;
    cmd_q.push_back('{1'b1, 24'h000456, 16'hBEEF});
    rdy_q.push_back('{1'b0, exp_rd0, 1'b0, 7});
    p0_read = 1'b1; p0_write = 1'b1;
    wait_in_wait("withdraw_wait");
    p0_read = 1'b0; p0_write = 1'b0;
    wait_ready(0, 30);
    repeat (4) @(negedge clki);

    // Controller never answers: watchdog aborts 17 cycles after the grant.
    model_hang = 1'b1;
    p1_addr = 24'h00ABCD;
    cmd_q.push_back('{1'b0, 24'h00ABCD, 16'h0000});
    rdy_q.push_back('{1'b1, exp_rd1, 1'b1, 16});
    p1_read = 1'b1;
    n = 0; got = 1'b0; last_cmd = 1'b0;
    while (!got && n < 40) begin
      @(negedge clki);
      n++;
      if (p1_ready) got = 1'b1;
      else last_cmd = sd_read;
    end
    p1_read = 1'b0;
    check("wd_latency", 64'(n), 64'd17);
    check("wd_cmd_before", 64'(last_cmd), 64'd1);
    check("wd_cmd_dropped", 64'(sd_read), 64'd0);
    model_hang = 1'b0;
    repeat (4) @(negedge clki);

    // Asynchronous reset in the wait phase, then a clean transaction.
    model_lat = 8;
    p1_addr = 24'h000777;
    cmd_q.push_back('{1'b0, 24'h000777, 16'h0000});
    p1_read = 1'b1;
    wait_in_wait("reset_wait");
    #2 rst_in = 1'b0;
    #1 check_zero("midreset");
    p1_read = 1'b0;
    repeat (2) @(negedge clki);
    rst_in = 1'b1;
    repeat (4) @(negedge clki);
    model_lat = 3; model_rdata = 32'hCAFE_F00D;
    p1_addr = 24'h000888;
    cmd_q.push_back('{1'b0, 24'h000888, 16'h0000});
    rdy_q.push_back('{1'b1, 32'hCAFE_F00D, 1'b0, 4});
    p1_read = 1'b1;
    wait_ready(1, 30);
    p1_read = 1'b0;
    repeat (10) @(negedge clki);

    check("ready_queue_drained", 64'(rdy_q.size()), 64'd0);
    check("cmd_queue_drained", 64'(cmd_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
